// File: rtl/id_stage.sv
// Decode stage of the five-stage LA32R pipeline: holds one fetched instruction,
// owns the 32x32 register file, stalls on RAW hazards and resolves branches.
module id_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic         fs_to_ds_valid,
    input  logic [63:0]  fs_to_ds_bus,
    output logic         ds_allowin,
    output logic [32:0]  br_bus,
    input  logic         es_allowin,
    output logic         ds_to_es_valid,
    output logic [137:0] ds_to_es_bus,
    input  logic [4:0]   es_dest,
    input  logic [4:0]   ms_dest,
    input  logic [37:0]  ws_to_rf_bus
);

    logic        ds_valid;
    logic [31:0] ds_pc;
    logic [31:0] ds_inst;
    logic        ds_ready_go;
    logic        hazard;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] br_target_raw;

    logic [4:0]  rd;
    logic [4:0]  rj;
    logic [4:0]  rk;

    assign rd = ds_inst[4:0];
    assign rj = ds_inst[9:5];
    assign rk = ds_inst[14:10];

    logic inst_add_w, inst_sub_w, inst_addi_w, inst_ld_w, inst_st_w;
    logic inst_lu12i_w, inst_jirl, inst_b, inst_bl, inst_beq, inst_bne;

    assign inst_add_w   = ds_inst[31:15] == 17'h00020;
    assign inst_sub_w   = ds_inst[31:15] == 17'h00022;
    assign inst_addi_w  = ds_inst[31:22] == 10'h00A;
    assign inst_ld_w    = ds_inst[31:22] == 10'h0A2;
    assign inst_st_w    = ds_inst[31:22] == 10'h0A6;
    assign inst_lu12i_w = ds_inst[31:25] == 7'h0A;
    assign inst_jirl    = ds_inst[31:26] == 6'h13;
    assign inst_b       = ds_inst[31:26] == 6'h14;
    assign inst_bl      = ds_inst[31:26] == 6'h15;
    assign inst_beq     = ds_inst[31:26] == 6'h16;
    assign inst_bne     = ds_inst[31:26] == 6'h17;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] rf [32];

    assign {rf_we, rf_waddr, rf_wdata} = ws_to_rf_bus;

    always_ff @(posedge clk) begin
        if (rf_we && rf_waddr != 5'd0) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    // Same-cycle writeback is forwarded so WB never causes a stall.
    logic [31:0] rj_value;
    logic [31:0] rk_value;
    logic [31:0] rkd_value;

    assign rj_value  = (rj == 5'd0) ? 32'd0 :
                       (rf_we && rf_waddr == rj) ? rf_wdata : rf[rj];
    assign rk_value  = (rk == 5'd0) ? 32'd0 :
                       (rf_we && rf_waddr == rk) ? rf_wdata : rf[rk];
    assign rkd_value = (rd == 5'd0) ? 32'd0 :
                       (rf_we && rf_waddr == rd) ? rf_wdata : rf[rd];

    logic [31:0] si12_ext;
    logic [31:0] lu12_imm;
    logic [31:0] offs16_ext;
    logic [31:0] offs26_ext;

    assign si12_ext   = {{20{ds_inst[21]}}, ds_inst[21:10]};
    assign lu12_imm   = {ds_inst[24:5], 12'b0};
    assign offs16_ext = {{14{ds_inst[25]}}, ds_inst[25:10], 2'b00};
    assign offs26_ext = {{4{ds_inst[9]}}, ds_inst[9:0], ds_inst[25:10], 2'b00};

    logic [31:0] src1;
    logic [31:0] src2;

    always_comb begin
        src1 = rj_value;
        src2 = rk_value;
        if (inst_addi_w || inst_ld_w || inst_st_w) begin
            src2 = si12_ext;
        end else if (inst_lu12i_w) begin
            src1 = 32'd0;
            src2 = lu12_imm;
        end else if (inst_bl || inst_jirl) begin
            src1 = ds_pc;
            src2 = 32'd4;
        end
    end

    logic [1:0] alu_op;
    logic [4:0] dest;
    logic       gr_we;
    logic       mem_we;
    logic       res_from_mem;

    assign alu_op       = inst_sub_w ? 2'b01 : 2'b00;
    assign dest         = inst_bl ? 5'd1 : rd;
    assign gr_we        = (inst_add_w || inst_sub_w || inst_addi_w || inst_ld_w ||
                           inst_lu12i_w || inst_bl || inst_jirl) && dest != 5'd0;
    assign mem_we       = inst_st_w;
    assign res_from_mem = inst_ld_w;

    logic reads_rj;
    logic reads_rk;
    logic reads_rd;
    logic rj_hit;
    logic rk_hit;
    logic rd_hit;

    assign reads_rj = inst_add_w || inst_sub_w || inst_addi_w || inst_ld_w ||
                      inst_st_w || inst_jirl || inst_beq || inst_bne;
    assign reads_rk = inst_add_w || inst_sub_w;
    assign reads_rd = inst_st_w || inst_beq || inst_bne;

    assign rj_hit = reads_rj && rj != 5'd0 && (rj == es_dest || rj == ms_dest);
    assign rk_hit = reads_rk && rk != 5'd0 && (rk == es_dest || rk == ms_dest);
    assign rd_hit = reads_rd && rd != 5'd0 && (rd == es_dest || rd == ms_dest);

    assign hazard         = ds_valid && (rj_hit || rk_hit || rd_hit);
    assign ds_ready_go    = !hazard;
    assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
    assign ds_to_es_valid = ds_valid && ds_ready_go;

    logic inst_taken;

    assign inst_taken = inst_b || inst_bl || inst_jirl ||
                        (inst_beq && rj_value == rkd_value) ||
                        (inst_bne && rj_value != rkd_value);

    assign br_target_raw = inst_jirl ? rj_value + offs16_ext :
                           ds_pc + ((inst_b || inst_bl) ? offs26_ext : offs16_ext);

    assign br_taken  = ds_valid && ds_ready_go && es_allowin && inst_taken;
    assign br_target = br_taken ? br_target_raw : 32'd0;
    assign br_bus    = {br_taken, br_target};

    // A taken branch leaving decode squashes the wrong-path fetch accepted alongside it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_valid <= 1'b0;
            ds_pc    <= 32'd0;
            ds_inst  <= 32'd0;
        end else if (ds_allowin) begin
            ds_valid <= fs_to_ds_valid && !br_taken;
            ds_pc    <= fs_to_ds_bus[63:32];
            ds_inst  <= fs_to_ds_bus[31:0];
        end
    end

    assign ds_to_es_bus = {alu_op, res_from_mem, mem_we, gr_we, dest,
                           rkd_value, src2, src1, ds_pc};

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed test-plan cases followed by random
// traffic, all compared against an instruction-level reference model.
module tb_id_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         fs_to_ds_valid;
    logic [63:0]  fs_to_ds_bus;
    logic         ds_allowin;
    logic [32:0]  br_bus;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [137:0] ds_to_es_bus;
    logic [4:0]   es_dest;
    logic [4:0]   ms_dest;
    logic [37:0]  ws_to_rf_bus;

    id_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .ds_allowin     (ds_allowin),
        .br_bus         (br_bus),
        .es_allowin     (es_allowin),
        .ds_to_es_valid (ds_to_es_valid),
        .ds_to_es_bus   (ds_to_es_bus),
        .es_dest        (es_dest),
        .ms_dest        (ms_dest),
        .ws_to_rf_bus   (ws_to_rf_bus)
    );

    always #5 clk = ~clk;

    localparam int K_NOP = 0, K_ADD = 1, K_SUB = 2, K_ADDI = 3, K_LD = 4, K_ST = 5;
    localparam int K_LU12I = 6, K_JIRL = 7, K_B = 8, K_BL = 9, K_BEQ = 10, K_BNE = 11;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] rfModel [32];
    logic        mValid;
    logic [31:0] mPc;
    logic [31:0] mInst;
    logic        savedAllow;
    logic        savedBrTaken;

    task automatic checkOutput(input string tag, input logic [137:0] observed,
                               input logic [137:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic int kindOf(input logic [31:0] i);
        if (i[31:15] == 17'h00020) return K_ADD;
        if (i[31:15] == 17'h00022) return K_SUB;
        if (i[31:22] == 10'h00A)   return K_ADDI;
        if (i[31:22] == 10'h0A2)   return K_LD;
        if (i[31:22] == 10'h0A6)   return K_ST;
        if (i[31:25] == 7'h0A)     return K_LU12I;
        case (i[31:26])
            6'h13:   return K_JIRL;
            6'h14:   return K_B;
            6'h15:   return K_BL;
            6'h16:   return K_BEQ;
            6'h17:   return K_BNE;
            default: return K_NOP;
        endcase
    endfunction

    function automatic logic [31:0] sextBits(input logic [31:0] v, input int bits);
        int s;
        s = int'(v);
        if (v[bits-1]) s = s - (1 << bits);
        return 32'(s);
    endfunction

    function automatic logic [31:0] rfRead(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (ws_to_rf_bus[37] && ws_to_rf_bus[36:32] == a) return ws_to_rf_bus[31:0];
        return rfModel[a];
    endfunction

    function automatic bit usesReg(input logic [4:0] r);
        return r != 5'd0 && (r == es_dest || r == ms_dest);
    endfunction

    // Compare the DUT against what the held instruction should produce this cycle.
    task automatic checkModel();
        int k;
        logic [4:0]  rj, rk, rd, dst;
        logic [31:0] vj, vk, vd, eSrc1, eSrc2, tgt;
        bit haz, taken, eValid, eBr, srcKnown, writes;
        k  = kindOf(mInst);
        rd = mInst[4:0];
        rj = mInst[9:5];
        rk = mInst[14:10];
        vj = rfRead(rj);
        vk = rfRead(rk);
        vd = rfRead(rd);
        haz = 0;
        if (k inside {K_ADD, K_SUB, K_ADDI, K_LD, K_ST, K_JIRL, K_BEQ, K_BNE} && usesReg(rj)) haz = 1;
        if (k inside {K_ADD, K_SUB} && usesReg(rk)) haz = 1;
        if (k inside {K_ST, K_BEQ, K_BNE} && usesReg(rd)) haz = 1;
        haz    = haz && mValid;
        eValid = mValid && !haz;
        savedAllow = !mValid || (!haz && es_allowin);
        taken = (k inside {K_B, K_BL, K_JIRL}) || (k == K_BEQ && vj == vd) || (k == K_BNE && vj != vd);
        eBr   = eValid && es_allowin && taken;
        savedBrTaken = eBr;
        if (k == K_JIRL)
            tgt = vj + 32'(sextBits({16'd0, mInst[25:10]}, 16) * 4);
        else if (k == K_B || k == K_BL)
            tgt = mPc + 32'(sextBits({6'd0, mInst[9:0], mInst[25:10]}, 26) * 4);
        else
            tgt = mPc + 32'(sextBits({16'd0, mInst[25:10]}, 16) * 4);
        checkOutput("allowin", ds_allowin, savedAllow);
        checkOutput("to_es_valid", ds_to_es_valid, eValid);
        checkOutput("br_bus", br_bus, eBr ? {1'b1, tgt} : 33'd0);
        if (eValid) begin
            dst    = (k == K_BL) ? 5'd1 : rd;
            writes = (k inside {K_ADD, K_SUB, K_ADDI, K_LD, K_LU12I, K_BL, K_JIRL}) && dst != 0;
            srcKnown = 1;
            case (k)
                K_ADD, K_SUB:        begin eSrc1 = vj;    eSrc2 = vk; end
                K_ADDI, K_LD, K_ST:  begin eSrc1 = vj;    eSrc2 = sextBits({20'd0, mInst[21:10]}, 12); end
                K_LU12I:             begin eSrc1 = 0;     eSrc2 = {mInst[24:5], 12'd0}; end
                K_BL, K_JIRL:        begin eSrc1 = mPc;   eSrc2 = 32'd4; end
                default:             begin eSrc1 = 0;     eSrc2 = 0; srcKnown = 0; end
            endcase
            checkOutput("alu_op", ds_to_es_bus[137:136], (k == K_SUB) ? 2'b01 : 2'b00);
            checkOutput("res_from_mem", ds_to_es_bus[135], k == K_LD);
            checkOutput("mem_we", ds_to_es_bus[134], k == K_ST);
            checkOutput("gr_we", ds_to_es_bus[133], writes);
            checkOutput("dest", ds_to_es_bus[132:128], dst);
            checkOutput("rkd_value", ds_to_es_bus[127:96], vd);
            checkOutput("pc", ds_to_es_bus[31:0], mPc);
            if (srcKnown) begin
                checkOutput("src2", ds_to_es_bus[95:64], eSrc2);
                checkOutput("src1", ds_to_es_bus[63:32], eSrc1);
            end
        end
    endtask

    task automatic applyStimulus(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                                 input logic ea, input logic [4:0] ed, input logic [4:0] md,
                                 input logic [37:0] ws);
        fs_to_ds_valid = fv;
        fs_to_ds_bus   = {pc, inst};
        es_allowin     = ea;
        es_dest        = ed;
        ms_dest        = md;
        ws_to_rf_bus   = ws;
        #1;
        checkModel();
    endtask

    task automatic stepClock();
        @(posedge clk);
        if (ws_to_rf_bus[37] && ws_to_rf_bus[36:32] != 5'd0)
            rfModel[ws_to_rf_bus[36:32]] = ws_to_rf_bus[31:0];
        if (savedAllow) begin
            mValid = fs_to_ds_valid && !savedBrTaken;
            mPc    = fs_to_ds_bus[63:32];
            mInst  = fs_to_ds_bus[31:0];
        end
        @(negedge clk);
    endtask

    task automatic modelReset();
        mValid = 0;
        mPc    = 0;
        mInst  = 0;
    endtask

    function automatic logic [31:0] randInst();
        logic [4:0]  rd, rj, rk;
        logic [31:0] r;
        rd = 5'($urandom_range(0, 7));
        rj = 5'($urandom_range(0, 7));
        rk = 5'($urandom_range(0, 7));
        r  = $urandom;
        case ($urandom_range(0, 11))
            0:       return {17'h00020, rk, rj, rd};
            1:       return {17'h00022, rk, rj, rd};
            2:       return {10'h00A, r[11:0], rj, rd};
            3:       return {10'h0A2, r[11:0], rj, rd};
            4:       return {10'h0A6, r[11:0], rj, rd};
            5:       return {7'h0A, r[19:0], rd};
            6:       return {6'h13, r[15:0], rj, rd};
            7:       return {6'h14, r[25:0]};
            8:       return {6'h15, r[25:0]};
            9:       return {6'h16, r[15:0], rj, rd};
            10:      return {6'h17, r[15:0], rj, rd};
            default: return r;
        endcase
    endfunction

    localparam logic [31:0] ADD_R3 = {17'h00020, 5'd2, 5'd1, 5'd3};
    localparam logic [31:0] BEQ_8  = {6'h16, 16'd2, 5'd0, 5'd0};
    localparam logic [31:0] ADDI_M = {10'h00A, 12'hFFF, 5'd1, 5'd4};
    localparam logic [31:0] ADD_R7 = {17'h00020, 5'd0, 5'd6, 5'd7};
    localparam logic [31:0] BL_100 = {6'h15, 16'h0040, 10'h000};

    initial begin
        resetn = 0;
        modelReset();
        fs_to_ds_valid = 0; fs_to_ds_bus = 0; es_allowin = 0;
        es_dest = 0; ms_dest = 0; ws_to_rf_bus = 0;
        @(negedge clk);
        #1;
        checkModel();
        checkOutput("reset_allowin", ds_allowin, 1'b1);
        checkOutput("reset_br_bus", br_bus, 33'd0);
        resetn = 1;
        @(negedge clk);

        for (int r = 0; r < 32; r++) begin
            logic [31:0] v;
            v = (r == 1) ? 32'd5 : (r == 2) ? 32'd7 : (r == 0) ? 32'hDEAD : 32'($urandom_range(0, 3));
            applyStimulus(0, 0, 0, 1, 0, 0, {1'b1, 5'(r), v});
            stepClock();
        end

        applyStimulus(1, 32'h1c000000, ADD_R3, 1, 0, 0, 0);
        stepClock();
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("plan_add_src1", ds_to_es_bus[63:32], 32'd5);
        checkOutput("plan_add_src2", ds_to_es_bus[95:64], 32'd7);
        stepClock();

        applyStimulus(1, 32'h1c000010, BEQ_8, 1, 0, 0, 0);
        stepClock();
        applyStimulus(1, 32'h1c000014, ADD_R3, 1, 0, 0, 0);
        checkOutput("plan_beq_br_bus", br_bus, 33'h1_1c000018);
        stepClock();
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("plan_squash", ds_to_es_valid, 1'b0);
        stepClock();

        applyStimulus(1, 32'h1c000030, ADDI_M, 1, 0, 0, 0);
        stepClock();
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1, 32'h1c000034, ADD_R3, 1, 5'd1, 0, 0);
            checkOutput("plan_stall_valid", ds_to_es_valid, 1'b0);
            stepClock();
        end
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("plan_addi_src2", ds_to_es_bus[95:64], 32'hFFFFFFFF);
        stepClock();

        applyStimulus(1, 32'h1c000040, ADD_R7, 1, 0, 0, 0);
        stepClock();
        applyStimulus(0, 0, 0, 1, 0, 0, {1'b1, 5'd6, 32'hABCD});
        checkOutput("plan_wt_src1", ds_to_es_bus[63:32], 32'hABCD);
        stepClock();

        applyStimulus(1, 32'h1c000020, BL_100, 1, 0, 0, 0);
        stepClock();
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("plan_bl_br_bus", br_bus, 33'h1_1c000120);
        checkOutput("plan_bl_dest", ds_to_es_bus[132:128], 5'd1);
        stepClock();

        applyStimulus(1, 32'h1c000050, 32'hFFFFFFFF, 1, 0, 0, 0);
        stepClock();
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("plan_undef_gr_we", ds_to_es_bus[133], 1'b0);
        stepClock();

        applyStimulus(1, 32'h1c000060, ADDI_M, 1, 0, 0, 0);
        stepClock();
        applyStimulus(1, 32'h1c000064, ADD_R3, 1, 5'd1, 0, 0);
        resetn = 0;
        modelReset();
        #1;
        checkOutput("rst_stall_valid", ds_to_es_valid, 1'b0);
        checkOutput("rst_stall_allowin", ds_allowin, 1'b1);
        checkOutput("rst_stall_br_bus", br_bus, 33'd0);
        resetn = 1;
        #1;
        checkModel();
        stepClock();

        for (int n = 0; n < 400; n++) begin
            logic [37:0] ws;
            logic [4:0]  ed, md;
            ws = {($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom)};
            ed = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 7)) : 5'd0;
            md = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 7)) : 5'd0;
            applyStimulus($urandom_range(0, 3) != 0, $urandom, randInst(),
                          $urandom_range(0, 3) != 0, ed, md, ws);
            stepClock();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
